// File: rtl/apb2axi_wr_burst_builder_if.sv
// Bundles the command/data FIFO pops, the AXI AW/W/B channels and the completion
// port of the write burst builder. "master" is the builder side, "slave" the environment.
interface apb2axi_wr_burst_builder_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int CMD_W      = 1 + AXI_ID_W + 3 + 8 + AXI_ADDR_W
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CMD_W-1:0]        cmd_data;
    logic                    wd_valid;
    logic                    wd_ready;
    logic [AXI_DATA_W-1:0]   wd_data;
    logic [AXI_DATA_W/8-1:0] wd_strb;
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic                    cpl_valid;
    logic [AXI_ID_W-1:0]     cpl_id;
    logic [1:0]              cpl_resp;
    logic                    cpl_ready;

    modport master (
        input  cmd_valid, cmd_data, output cmd_ready,
        input  wd_valid, wd_data, wd_strb, output wd_ready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid, output bready,
        output cpl_valid, cpl_id, cpl_resp,
        input  cpl_ready
    );

    modport slave (
        output cmd_valid, cmd_data, input cmd_ready,
        output wd_valid, wd_data, wd_strb, input wd_ready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid, input bready,
        input  cpl_valid, cpl_id, cpl_resp,
        output cpl_ready
    );
endinterface

// File: rtl/apb2axi_wr_burst_builder.sv
// Turns write commands into one AXI AW plus len+1 W beats each, and forwards
// B responses to the completion path while counting outstanding writes.
module apb2axi_wr_burst_builder #(
    parameter int AXI_ID_W        = 4,
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_DATA_W      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CMD_W           = 1 + AXI_ID_W + 3 + 8 + AXI_ADDR_W
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    apb2axi_wr_burst_builder_if.master         bus,
    output logic [3:0]                         outstanding,
    output logic                               cmd_drop,
    output logic                               b_unexp
);
    localparam int         LEN_LSB  = AXI_ADDR_W;
    localparam int         SIZE_LSB = AXI_ADDR_W + 8;
    localparam int         ID_LSB   = AXI_ADDR_W + 11;
    localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_W = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            len_q, len_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic                  cmd_drop_q, cmd_drop_d;
    logic                  b_unexp_q, b_unexp_d;

    logic cmd_ready_w, cmd_hs, aw_hs, w_hs, b_hs, last_beat;

    assign last_beat = (beat_cnt_q == len_q);
    assign b_hs      = bus.bvalid & bus.cpl_ready;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        size_d      = size_q;
        len_d       = len_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        cmd_drop_d  = 1'b0;
        cmd_ready_w = 1'b0;
        cmd_hs      = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        bus.awvalid  = 1'b0;
        bus.wvalid   = 1'b0;
        bus.wd_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_w = (outstanding_q < MAX_OUT);
                cmd_hs      = bus.cmd_valid & cmd_ready_w;
                if (cmd_hs) begin
                    if (bus.cmd_data[CMD_W-1]) begin
                        id_d       = bus.cmd_data[ID_LSB +: AXI_ID_W];
                        size_d     = bus.cmd_data[SIZE_LSB +: 3];
                        len_d      = bus.cmd_data[LEN_LSB +: 8];
                        addr_d     = bus.cmd_data[AXI_ADDR_W-1:0];
                        beat_cnt_d = 8'd0;
                        state_d    = S_AW;
                    end else begin
                        cmd_drop_d = 1'b1;
                    end
                end
            end
            S_AW: begin
                bus.awvalid = 1'b1;
                aw_hs       = bus.awready;
                if (aw_hs) state_d = S_W;
            end
            S_W: begin
                bus.wvalid   = bus.wd_valid;
                bus.wd_ready = bus.wready;
                w_hs         = bus.wd_valid & bus.wready;
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Simultaneous AW and B handshakes cancel; a B with nothing outstanding is flagged, not counted.
    always_comb begin
        outstanding_d = outstanding_q;
        b_unexp_d     = b_unexp_q;
        if (b_hs && (outstanding_q == 4'd0)) b_unexp_d = 1'b1;
        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   if (outstanding_q != 4'd0) outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            id_q          <= '0;
            size_q        <= '0;
            len_q         <= '0;
            addr_q        <= '0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            cmd_drop_q    <= 1'b0;
            b_unexp_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            size_q        <= size_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            cmd_drop_q    <= cmd_drop_d;
            b_unexp_q     <= b_unexp_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_w;
    assign bus.awid      = id_q;
    assign bus.awaddr    = addr_q;
    assign bus.awlen     = len_q;
    assign bus.awsize    = size_q;
    assign bus.awburst   = 2'b01;
    assign bus.awlock    = 1'b0;
    assign bus.awcache   = 4'b0011;
    assign bus.awprot    = 3'b000;
    assign bus.wdata     = bus.wd_data;
    assign bus.wstrb     = bus.wd_strb;
    assign bus.wlast     = last_beat;
    assign bus.bready    = bus.cpl_ready;
    assign bus.cpl_valid = bus.bvalid;
    assign bus.cpl_id    = bus.bid;
    assign bus.cpl_resp  = bus.bresp;

    assign outstanding = outstanding_q;
    assign cmd_drop    = cmd_drop_q;
    assign b_unexp     = b_unexp_q;
endmodule

// File: tb/tb_apb2axi_wr_burst_builder.sv
// Bench for the write burst builder: vector table, hand-written corner sequences
// and a randomized run scored against a queue-based model of the expected traffic.
module tb_apb2axi_wr_burst_builder;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic [3:0] outstanding;
    logic       cmd_drop;
    logic       b_unexp;

    apb2axi_wr_burst_builder_if bus ();

    apb2axi_wr_burst_builder dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .bus         (bus),
        .outstanding (outstanding),
        .cmd_drop    (cmd_drop),
        .b_unexp     (b_unexp)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_out = 0;

    typedef struct {
        bit          is_write;
        logic [3:0]  id;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
        int          aw_stall;
        bit          gap;
        logic [1:0]  resp;
        bit          exp_drop;
        logic [31:0] exp_awaddr;
        logic [7:0]  exp_awlen;
        int          exp_beats;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mk_cmd(bit w, logic [3:0] id, logic [2:0] size,
                                           logic [7:0] len, logic [31:0] addr);
        return {w, id, size, len, addr};
    endfunction

    function automatic logic [63:0] beat_data(logic [31:0] addr, int k);
        return {addr, 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [7:0] beat_strb(int k);
        return 8'hFF ^ 8'(k);
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_data = '0;
        bus.wd_valid  = 1'b0; bus.wd_data  = '0; bus.wd_strb = '0;
        bus.awready   = 1'b0; bus.wready   = 1'b0;
        bus.bvalid    = 1'b0; bus.bid      = '0; bus.bresp   = '0;
        bus.cpl_ready = 1'b0;
    endtask

    // One command end to end: pop, AW (with optional stall), W burst, optional B.
    task automatic do_cmd(input vec_t v, input bit send_b, input int abort_beat);
        int hs;
        int cyc;
        @(negedge aclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = mk_cmd(v.is_write, v.id, v.size, v.len, v.addr);
        #1;
        check("cmd_ready", bus.cmd_ready, 1);
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.wd_valid  = 1'b1;
        bus.wready    = 1'b1;
        #1;
        check("cmd_drop", cmd_drop, v.exp_drop);
        check("wvalid_before_aw", bus.wvalid, 0);
        check("wd_ready_before_aw", bus.wd_ready, 0);
        if (!v.is_write) begin
            check("drop_awvalid", bus.awvalid, 0);
            @(negedge aclk);
            #1;
            check("drop_pulse_end", cmd_drop, 0);
            check("drop_awvalid2", bus.awvalid, 0);
            check("drop_outstanding", outstanding, exp_out);
            bus.wd_valid = 1'b0;
            bus.wready   = 1'b0;
            $display("[TB] drop id=%0d", v.id);
            return;
        end
        check("awvalid", bus.awvalid, 1);
        check("awaddr", bus.awaddr, v.exp_awaddr);
        check("awlen", bus.awlen, v.exp_awlen);
        check("awid", bus.awid, v.id);
        check("awsize", bus.awsize, v.size);
        check("awburst", bus.awburst, 2'b01);
        check("awlock", bus.awlock, 0);
        check("awcache", bus.awcache, 4'b0011);
        check("awprot", bus.awprot, 0);
        repeat (v.aw_stall) begin
            @(negedge aclk);
            #1;
            check("aw_hold_valid", bus.awvalid, 1);
            check("aw_hold_addr", bus.awaddr, v.exp_awaddr);
            check("aw_hold_len", bus.awlen, v.exp_awlen);
            check("aw_hold_id", bus.awid, v.id);
        end
        bus.awready = 1'b1;
        exp_out++;
        hs  = 0;
        cyc = 0;
        while (hs < v.exp_beats && cyc < 200) begin
            @(negedge aclk);
            bus.awready = 1'b0;
            if (hs == abort_beat) return;
            bus.wready   = v.gap ? (cyc % 2 == 0) : 1'b1;
            bus.wd_valid = v.gap ? (cyc % 3 != 2) : 1'b1;
            bus.wd_data  = beat_data(v.addr, hs);
            bus.wd_strb  = beat_strb(hs);
            #1;
            check("w_awvalid_low", bus.awvalid, 0);
            check("wvalid_follow", bus.wvalid, bus.wd_valid);
            check("wlast", bus.wlast, (hs == v.exp_beats - 1));
            if (bus.wvalid && bus.wready) begin
                check("wdata", bus.wdata, beat_data(v.addr, hs));
                check("wstrb", bus.wstrb, beat_strb(hs));
                hs++;
            end
            cyc++;
        end
        check("w_beats", hs, v.exp_beats);
        @(negedge aclk);
        bus.wd_valid = 1'b0;
        bus.wready   = 1'b0;
        #1;
        check("post_burst_cmd_ready", bus.cmd_ready, (exp_out < 4));
        check("post_burst_outstanding", outstanding, exp_out);
        $display("[TB] write id=%0d addr=0x%0h beats=%0d", v.id, v.addr, hs);
        if (send_b) begin
            @(negedge aclk);
            bus.bvalid = 1'b1; bus.bid = v.id; bus.bresp = v.resp; bus.cpl_ready = 1'b1;
            #1;
            check("cpl_valid", bus.cpl_valid, 1);
            check("cpl_id", bus.cpl_id, v.id);
            check("cpl_resp", bus.cpl_resp, v.resp);
            check("bready", bus.bready, 1);
            @(negedge aclk);
            bus.bvalid = 1'b0; bus.cpl_ready = 1'b0;
            exp_out--;
            #1;
            check("b_outstanding", outstanding, exp_out);
            $display("[TB] bresp id=%0d resp=%0d", v.id, v.resp);
        end
    endtask

    task automatic one_b(input logic [3:0] id);
        @(negedge aclk);
        bus.bvalid = 1'b1; bus.bid = id; bus.bresp = 2'b00; bus.cpl_ready = 1'b1;
        #1;
        check("drain_cpl_valid", bus.cpl_valid, 1);
        @(negedge aclk);
        bus.bvalid = 1'b0; bus.cpl_ready = 1'b0;
        exp_out--;
        #1;
        check("drain_outstanding", outstanding, exp_out);
    endtask

    // Reference model state for the randomized run.
    typedef struct {
        logic [3:0]  id;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
    } aw_t;
    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        bit          last;
    } beat_t;

    logic [47:0] cmd_q[$];
    aw_t         aw_exp[$];
    beat_t       w_exp[$];
    beat_t       wd_q[$];
    logic [3:0]  b_pend[$];

    task automatic random_run();
        int  drops_exp = 0;
        int  drops_seen = 0;
        int  writes_acc = 0;
        int  aws_seen = 0;
        int  bursts_done = 0;
        bit  drop_exp_now = 0;
        int  cyc = 0;
        for (int i = 0; i < 24; i++) begin
            aw_t   a;
            beat_t b;
            bit    w;
            w      = ($urandom_range(0, 4) != 0);
            a.id   = 4'($urandom);
            a.size = 3'($urandom_range(0, 3));
            a.len  = 8'($urandom_range(0, 9));
            a.addr = $urandom;
            cmd_q.push_back(mk_cmd(w, a.id, a.size, a.len, a.addr));
            if (w) begin
                aw_exp.push_back(a);
                for (int k = 0; k <= int'(a.len); k++) begin
                    b.data = {$urandom, $urandom};
                    b.strb = 8'($urandom);
                    b.last = (k == int'(a.len));
                    wd_q.push_back(b);
                    w_exp.push_back(b);
                end
            end else begin
                drops_exp++;
            end
        end
        while ((cmd_q.size() + w_exp.size() + b_pend.size()) > 0 && cyc < 6000) begin
            bit cmd_pop, aw_take, w_take, b_take;
            @(negedge aclk);
            bus.cmd_valid = (cmd_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.cmd_data  = (cmd_q.size() > 0) ? cmd_q[0] : '0;
            bus.wd_valid  = (wd_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.wd_data   = (wd_q.size() > 0) ? wd_q[0].data : '0;
            bus.wd_strb   = (wd_q.size() > 0) ? wd_q[0].strb : '0;
            bus.awready   = ($urandom_range(0, 2) != 0);
            bus.wready    = ($urandom_range(0, 2) != 0);
            bus.bvalid    = (b_pend.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.bid       = (b_pend.size() > 0) ? b_pend[0] : '0;
            bus.bresp     = 2'($urandom);
            bus.cpl_ready = ($urandom_range(0, 1) != 0);
            #1;
            // Expected outputs from the counts of commands, AWs and bursts seen so far.
            check("rnd_outstanding", outstanding, b_pend.size());
            check("rnd_cmd_drop", cmd_drop, drop_exp_now);
            check("rnd_cmd_ready", bus.cmd_ready,
                  (writes_acc == bursts_done) && (b_pend.size() < 4));
            check("rnd_awvalid", bus.awvalid, (writes_acc - aws_seen) == 1);
            check("rnd_wvalid", bus.wvalid, ((aws_seen - bursts_done) == 1) && bus.wd_valid);
            check("rnd_wd_ready", bus.wd_ready, ((aws_seen - bursts_done) == 1) && bus.wready);
            cmd_pop = bus.cmd_valid && bus.cmd_ready;
            aw_take = bus.awvalid && bus.awready;
            w_take  = bus.wvalid && bus.wready;
            b_take  = bus.bvalid && bus.bready;
            drop_exp_now = 0;
            if (cmd_drop) drops_seen++;
            if (cmd_pop) begin
                if (cmd_q[0][47]) writes_acc++;
                else drop_exp_now = 1;
                void'(cmd_q.pop_front());
            end
            if (aw_take) begin
                aw_t a;
                a = aw_exp.pop_front();
                check("rnd_awid", bus.awid, a.id);
                check("rnd_awaddr", bus.awaddr, a.addr);
                check("rnd_awlen", bus.awlen, a.len);
                check("rnd_awsize", bus.awsize, a.size);
                b_pend.push_back(a.id);
                aws_seen++;
                $display("[TB] rnd aw id=%0d addr=0x%0h len=%0d", a.id, a.addr, a.len);
            end
            if (w_take) begin
                beat_t b;
                b = w_exp.pop_front();
                check("rnd_wdata", bus.wdata, b.data);
                check("rnd_wstrb", bus.wstrb, b.strb);
                check("rnd_wlast", bus.wlast, b.last);
                void'(wd_q.pop_front());
                if (b.last) bursts_done++;
            end
            if (b_take) begin
                check("rnd_cpl_id", bus.cpl_id, b_pend[0]);
                check("rnd_cpl_resp", bus.cpl_resp, bus.bresp);
                check("rnd_cpl_valid", bus.cpl_valid, 1);
                void'(b_pend.pop_front());
            end
            cyc++;
        end
        check("rnd_drain_timeout", cmd_q.size() + w_exp.size() + b_pend.size(), 0);
        @(negedge aclk);
        idle_inputs();
        #1;
        if (cmd_drop) drops_seen++;
        check("rnd_drops", drops_seen, drops_exp);
        check("rnd_b_unexp", b_unexp, 0);
        check("rnd_final_outstanding", outstanding, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t mid;
        vecs[0] = '{1'b1, 4'd3,  3'd3, 8'd0,  32'h0000_1000, 0, 1'b0, 2'b00, 1'b0, 32'h0000_1000, 8'd0,  1};
        vecs[1] = '{1'b1, 4'd5,  3'd3, 8'd7,  32'h0000_2000, 5, 1'b1, 2'b10, 1'b0, 32'h0000_2000, 8'd7,  8};
        vecs[2] = '{1'b0, 4'd2,  3'd3, 8'd3,  32'h0000_3000, 0, 1'b0, 2'b00, 1'b1, 32'h0000_0000, 8'd0,  0};
        vecs[3] = '{1'b1, 4'd15, 3'd2, 8'd15, 32'hFFFF_FFF0, 1, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFF0, 8'd15, 16};
        mid     = '{1'b1, 4'd9,  3'd3, 8'd7,  32'h0000_4000, 0, 1'b0, 2'b00, 1'b0, 32'h0000_4000, 8'd7,  8};

        idle_inputs();
        aresetn = 1'b0;
        #2;
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_wd_ready", bus.wd_ready, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_wlast", bus.wlast, 1);
        check("rst_outstanding", outstanding, 0);
        check("rst_cmd_drop", cmd_drop, 0);
        check("rst_b_unexp", b_unexp, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 4; i++) do_cmd(vecs[i], 1'b1, -1);

        // Outstanding limit: four writes without B, fifth waits for a response.
        for (int i = 0; i < 4; i++) do_cmd(vecs[0], 1'b0, -1);
        @(negedge aclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = mk_cmd(1'b1, 4'd6, 3'd3, 8'd0, 32'h0000_5000);
        #1;
        check("limit_cmd_ready", bus.cmd_ready, 0);
        check("limit_outstanding", outstanding, 4);
        @(negedge aclk);
        bus.bvalid = 1'b1; bus.bid = 4'd3; bus.cpl_ready = 1'b1;
        #1;
        check("limit_cmd_ready_b_cycle", bus.cmd_ready, 0);
        @(negedge aclk);
        bus.bvalid = 1'b0; bus.cpl_ready = 1'b0;
        exp_out = 3;
        #1;
        check("limit_cmd_ready_after_b", bus.cmd_ready, 1);
        check("limit_outstanding_after_b", outstanding, 3);
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        #1;
        check("limit_awvalid", bus.awvalid, 1);
        check("limit_awaddr", bus.awaddr, 32'h0000_5000);
        bus.awready = 1'b1; bus.bvalid = 1'b1; bus.bid = 4'd3; bus.cpl_ready = 1'b1;
        @(negedge aclk);
        bus.awready = 1'b0; bus.bvalid = 1'b0; bus.cpl_ready = 1'b0;
        bus.wd_valid = 1'b1; bus.wready = 1'b1; bus.wd_data = 64'h1234; bus.wd_strb = 8'hFF;
        #1;
        check("simul_aw_b_outstanding", outstanding, 3);
        check("limit_wlast", bus.wlast, 1);
        check("limit_wvalid", bus.wvalid, 1);
        @(negedge aclk);
        bus.wd_valid = 1'b0; bus.wready = 1'b0;
        for (int i = 0; i < 3; i++) one_b(4'd3);
        $display("[TB] limit sequence done, outstanding=%0d", outstanding);

        // Stray B with nothing outstanding.
        @(negedge aclk);
        bus.bvalid = 1'b1; bus.bid = 4'd5; bus.bresp = 2'b10; bus.cpl_ready = 1'b1;
        #1;
        check("stray_cpl_valid", bus.cpl_valid, 1);
        check("stray_cpl_id", bus.cpl_id, 5);
        check("stray_cpl_resp", bus.cpl_resp, 2'b10);
        @(negedge aclk);
        bus.bvalid = 1'b0; bus.cpl_ready = 1'b0;
        #1;
        check("stray_b_unexp", b_unexp, 1);
        check("stray_outstanding", outstanding, 0);
        @(negedge aclk);
        #1;
        check("stray_b_unexp_sticky", b_unexp, 1);
        $display("[TB] stray bresp id=5");

        // Reset asserted at beat 3 of an 8-beat burst.
        do_cmd(mid, 1'b0, 3);
        bus.wd_valid = 1'b1; bus.wready = 1'b1;
        #1;
        check("midrst_pre_wvalid", bus.wvalid, 1);
        aresetn = 1'b0;
        #1;
        check("midrst_awvalid", bus.awvalid, 0);
        check("midrst_wvalid", bus.wvalid, 0);
        check("midrst_wd_ready", bus.wd_ready, 0);
        check("midrst_outstanding", outstanding, 0);
        check("midrst_b_unexp", b_unexp, 0);
        @(negedge aclk);
        idle_inputs();
        aresetn = 1'b1;
        exp_out = 0;
        $display("[TB] reset mid-burst at beat 3");
        do_cmd(vecs[0], 1'b1, -1);

        random_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb2axi_wr_burst_builder.md
# apb2axi_wr_burst_builder

Parametrised successor to the single-beat write builder. Pops write commands from the write command FIFO and issues one AXI AW per command. Then streams `len+1` W beats from a separate write-data FIFO, with WLAST on the final beat. Tracks outstanding B responses against a configurable limit and forwards each B response to the completion path.

## Interface
Parameters:
- `AXI_ID_W`, 4: AWID/BID width; carried in the command entry.
- `AXI_ADDR_W`, 32: address width.
- `AXI_DATA_W`, 64: data width; strobe width is `AXI_DATA_W/8`.
- `MAX_OUTSTANDING`, 4: max AW issued without a returned B (1..15).
- `CMD_W`, `1+AXI_ID_W+3+8+AXI_ADDR_W`: command entry `{is_write, id, size[2:0], len[7:0], addr}`, MSB first.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1 / `cmd_data` in CMD_W: command FIFO pop interface.
- `wd_valid` in 1 / `wd_ready` out 1: write-data FIFO pop handshake.
- `wd_data` in AXI_DATA_W / `wd_strb` in AXI_DATA_W/8: data FIFO payload.
- `awid`, `awaddr`, `awlen[7:0]`, `awsize[2:0]`, `awburst[1:0]`, `awlock`, `awcache[3:0]`, `awprot[2:0]` out; `awvalid` out 1; `awready` in 1: AXI AW channel.
- `wdata`, `wstrb`, `wlast`, `wvalid` out; `wready` in: AXI W channel.
- `bid` in AXI_ID_W, `bresp` in 2, `bvalid` in 1 / `bready` out 1: AXI B channel.
- `cpl_valid` out 1, `cpl_id` out AXI_ID_W, `cpl_resp` out 2 / `cpl_ready` in 1: completion output.
- `outstanding` out 4: current count of AWs awaiting a B response.
- `cmd_drop` out 1: one-cycle pulse when a command with `is_write=0` is discarded.
- `b_unexp` out 1: sticky; set by a B handshake when `outstanding==0`.

## Operation
- FSM with states IDLE, AW, W.
- **IDLE:** `cmd_ready = (outstanding < MAX_OUTSTANDING)`.
  - On a handshake with `is_write=1`, latch id/size/len/addr into registers, clear `beat_cnt`, and go to AW.
  - On a handshake with `is_write=0`, pulse `cmd_drop` next cycle and stay in IDLE.
- **AW:** `awvalid=1`; fields driven from the latched registers.
  - Fixed fields: `awburst=2'b01` (INCR), `awlock=0`, `awcache=4'b0011`, `awprot=0`.
  - Hold `awvalid` and all AW fields stable until `awready`. On the handshake, go to W.
- **W:** `wvalid = wd_valid`, `wd_ready = wready`. `wdata`/`wstrb` pass through combinationally from `wd_data`/`wd_strb`.
  - `wlast = (beat_cnt == len_q)`.
  - Each W handshake increments `beat_cnt` (8-bit).
  - The handshake with `wlast=1` returns the FSM to IDLE.
- **B path (independent of FSM):** `cpl_valid=bvalid`, `cpl_id=bid`, `cpl_resp=bresp`, `bready=cpl_ready`. Any `bresp` is forwarded unmodified.
- **Outstanding counter:** +1 on AW handshake, −1 on B handshake; unchanged when both occur in the same cycle.
  - A B handshake at 0 leaves the count at 0 and sets `b_unexp`.
  - The count never exceeds MAX_OUTSTANDING, because `cmd_ready` gates new commands.
- `awlen=0` gives a single beat with `wlast` on the first beat. No 4 KB boundary check is performed; the upstream block guarantees legal bursts.

## Timing
- **Reset** (asynchronous assert, synchronous release): FSM=IDLE, `beat_cnt=0`, `outstanding=0`, `cmd_drop=0`, `b_unexp=0`, all latched fields 0.
  - Consequently `awvalid=0`, `wvalid=0`, `wd_ready=0`, `cmd_ready=1`, `wlast=1` (len_q=0, but gated by `wvalid=0`).
  - Mid-burst reset abandons the transaction immediately. There is no recovery of partial bursts.
- **Latency:** command handshake in cycle N → `awvalid=1` in N+1.
  - AW handshake in cycle M → first `wvalid` possible in M+1.
  - Last W handshake in cycle K → IDLE in K+1, so the next `cmd_ready` is possible in K+1.
- **Throughput:** 1 W beat per cycle while `wd_valid & wready`. Minimum per-command overhead is 2 cycles (IDLE and AW).
- W beats never precede their AW handshake. AW for command n+1 is never issued before the W burst of command n completes.
- `wvalid` de-asserts when the data FIFO is empty. The AXI stability rule is preserved because the FIFO holds its head until `wd_ready`.
- `outstanding==MAX_OUTSTANDING` in IDLE → `cmd_ready=0`. A B handshake that cycle lets `cmd_ready` rise the next cycle.

## Test plan
- **Single write:** cmd `{1, id=3, size=3, len=0, addr=0x1000}`.
  - Required: AW with `awaddr=0x1000`, `awlen=0`, `awid=3` in cycle N+1.
  - One W beat with `wlast=1`; `outstanding` becomes 1.
  - `bvalid`/`bid=3`/`bresp=0` → `cpl_valid` with `cpl_id=3`; `outstanding` returns to 0.
- **Burst with stalls:** `len=7`, `wready` low every other cycle, `wd_valid` gapped.
  - Required: exactly 8 W handshakes, data in FIFO order, `wlast` only on the 8th.
  - AW fields stable under an `awready` stall of 5 cycles.
- **Outstanding limit:** MAX=4, `bvalid=0`, push 5 commands.
  - Required: 4 AWs issued; `cmd_ready=0` with `outstanding=4`.
  - After one B, the 5th command is accepted next cycle.
  - Simultaneous AW and B handshakes hold the count.
- **Non-write command:** `is_write=0` → popped, `cmd_drop` pulses once, no AXI activity.
  - Stray B at `outstanding=0` → forwarded on completion, `b_unexp=1`.
- **Reset mid-burst:** assert `aresetn=0` at beat 3 of 8.
  - Required: `awvalid`/`wvalid`/`wd_ready` low asynchronously; `outstanding=0`.
  - After release, the next command runs normally.
